// File: rtl/pool_dropout_engine_if.sv
// Bus bundle for pool_dropout_engine: layer-controller handshake plus the input-SRAM
// read port and the output-SRAM write port.
//   start/abort/pool_mode/training_mode : controller -> engine
//   busy/done                           : engine -> controller
//   in_addr/in_rd_en, in_data           : input SRAM read port (data one cycle after strobe)
//   out_addr/out_wr_en/out_data         : output SRAM write port
//   drop_count                          : only with POOL_DROPOUT_STATS_EN defined
// master = engine side, slave = controller/memory side.
interface pool_dropout_engine_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IN_AW      = 6,
    parameter int unsigned OUT_AW     = 4
);
    logic                  start;
    logic                  abort;
    logic                  pool_mode;
    logic                  training_mode;
    logic                  busy;
    logic                  done;
    logic [IN_AW-1:0]      in_addr;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OUT_AW-1:0]     out_addr;
    logic                  out_wr_en;
    logic [DATA_WIDTH-1:0] out_data;
`ifdef POOL_DROPOUT_STATS_EN
    logic [15:0]           drop_count;
`endif

    modport master (
        input  start, abort, pool_mode, training_mode, in_data,
`ifdef POOL_DROPOUT_STATS_EN
        output drop_count,
`endif
        output busy, done, in_addr, in_rd_en, out_addr, out_wr_en, out_data
    );

    modport slave (
        output start, abort, pool_mode, training_mode, in_data,
`ifdef POOL_DROPOUT_STATS_EN
        input  drop_count,
`endif
        input  busy, done, in_addr, in_rd_en, out_addr, out_wr_en, out_data
    );
endinterface

// File: rtl/pool_dropout_engine.sv
// Multi-channel max/average pooling engine with LFSR dropout.
// Reads each pooling window from an external input SRAM (planar, channel-major), reduces it,
// optionally zeroes the result when the LFSR draw falls below DROP_THRESH (training mode),
// and writes one element per window to an external output SRAM.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pool_dropout_engine_if.master (handshake + SRAM ports)
// Optional feature: define POOL_DROPOUT_STATS_EN to add bus.drop_count, a saturating count of
// dropped outputs in the current run.
module pool_dropout_engine #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned IN_ROWS     = 6,
    parameter int unsigned IN_COLS     = 6,
    parameter int unsigned SEG_ROWS    = 2,
    parameter int unsigned SEG_COLS    = 2,
    parameter int unsigned STRIDE_ROWS = 2,
    parameter int unsigned STRIDE_COLS = 2,
    parameter int unsigned PADDING     = 1,
    parameter int unsigned DROP_THRESH = 128,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                   clk,
    input logic                   rst_n,
    pool_dropout_engine_if.master bus
);
    localparam int unsigned OUT_ROWS  = (PADDING != 0) ? ((IN_ROWS - 1) / STRIDE_ROWS) + 1
                                                       : ((IN_ROWS - SEG_ROWS) / STRIDE_ROWS) + 1;
    localparam int unsigned OUT_COLS  = (PADDING != 0) ? ((IN_COLS - 1) / STRIDE_COLS) + 1
                                                       : ((IN_COLS - SEG_COLS) / STRIDE_COLS) + 1;
    localparam int unsigned IN_DEPTH  = CHANNELS * IN_ROWS * IN_COLS;
    localparam int unsigned OUT_DEPTH = CHANNELS * OUT_ROWS * OUT_COLS;
    localparam int unsigned IN_AW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int unsigned OUT_AW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned WIN       = SEG_ROWS * SEG_COLS;
    localparam int unsigned SHIFT     = $clog2(WIN);
    localparam int unsigned SUM_W     = DATA_WIDTH + SHIFT;
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned OR_W      = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int unsigned OC_W      = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
    localparam int unsigned KR_W      = (SEG_ROWS > 1) ? $clog2(SEG_ROWS) : 1;
    localparam int unsigned KC_W      = (SEG_COLS > 1) ? $clog2(SEG_COLS) : 1;
    localparam logic [8:0]  THRESH9   = {1'b0, 8'(DROP_THRESH)};

    // Averaging is a shift, so the window size has to be a power of two.
    if ((WIN & (WIN - 1)) != 0) begin : g_win_not_pow2
        $error("SEG_ROWS*SEG_COLS must be a power of two");
    end

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StFinish} state_e;

    // Valid rows/cols of a window; edge windows are truncated when PADDING=1.
    function automatic int unsigned row_lim(input int unsigned orow);
        int unsigned r0;
        r0 = orow * STRIDE_ROWS;
        return (r0 + SEG_ROWS > IN_ROWS) ? IN_ROWS - r0 : SEG_ROWS;
    endfunction

    function automatic int unsigned col_lim(input int unsigned ocol);
        int unsigned c0;
        c0 = ocol * STRIDE_COLS;
        return (c0 + SEG_COLS > IN_COLS) ? IN_COLS - c0 : SEG_COLS;
    endfunction

    function automatic logic [IN_AW-1:0] in_addr_f(input int unsigned ch, input int unsigned orow,
                                                   input int unsigned ocol, input int unsigned kr,
                                                   input int unsigned kc);
        return IN_AW'(ch * IN_ROWS * IN_COLS + (orow * STRIDE_ROWS + kr) * IN_COLS
                      + ocol * STRIDE_COLS + kc);
    endfunction

    function automatic logic [OUT_AW-1:0] out_addr_f(input int unsigned ch,
                                                     input int unsigned orow,
                                                     input int unsigned ocol);
        return OUT_AW'(ch * OUT_ROWS * OUT_COLS + orow * OUT_COLS + ocol);
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    state_e                state_q, state_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [IN_AW-1:0]      in_addr_q, in_addr_d;
    logic [OUT_AW-1:0]     out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [OR_W-1:0]       orow_q, orow_d;
    logic [OC_W-1:0]       ocol_q, ocol_d;
    logic [KR_W-1:0]       kr_q, kr_d;
    logic [KC_W-1:0]       kc_q, kc_d;
    logic [SUM_W-1:0]      acc_q, acc_d, acc_new;
    logic                  data_vld_q, data_vld_d;
    logic                  pool_mode_q, pool_mode_d, train_q, train_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] pooled;
    logic [8:0]            thresh_diff;
    logic                  drop, issue_rd;
`ifdef POOL_DROPOUT_STATS_EN
    logic [15:0]           drop_cnt_q, drop_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        in_addr_d   = in_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        ch_d        = ch_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        pool_mode_d = pool_mode_q;
        train_d     = train_q;
        lfsr_d      = lfsr_q;
        data_vld_d  = rd_en_q;
        issue_rd    = 1'b0;
`ifdef POOL_DROPOUT_STATS_EN
        drop_cnt_d  = drop_cnt_q;
`endif

        // Fold in the element whose read was issued last cycle.
        if (!data_vld_q) begin
            acc_new = acc_q;
        end else if (pool_mode_q) begin
            acc_new = acc_q + SUM_W'(bus.in_data);
        end else begin
            acc_new = (SUM_W'(bus.in_data) > acc_q) ? SUM_W'(bus.in_data) : acc_q;
        end
        acc_d  = acc_new;
        pooled = pool_mode_q ? DATA_WIDTH'(acc_new >> SHIFT) : acc_new[DATA_WIDTH-1:0];

        // Borrow out of lfsr[7:0] - DROP_THRESH means lfsr[7:0] < DROP_THRESH.
        thresh_diff = {1'b0, lfsr_q[7:0]} - THRESH9;
        drop        = train_q && thresh_diff[8];

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pool_mode_d = bus.pool_mode;
                    train_d     = bus.training_mode;
                    ch_d        = '0;
                    orow_d      = '0;
                    ocol_d      = '0;
                    kr_d        = '0;
                    kc_d        = '0;
                    acc_d       = '0;
                    busy_d      = 1'b1;
                    issue_rd    = 1'b1;
                    state_d     = StRead;
`ifdef POOL_DROPOUT_STATS_EN
                    drop_cnt_d  = '0;
`endif
                end
            end
            StRead: begin
                if (32'(kc_q) + 1 < col_lim(32'(ocol_q))) begin
                    kc_d     = kc_q + 1'b1;
                    issue_rd = 1'b1;
                end else if (32'(kr_q) + 1 < row_lim(32'(orow_q))) begin
                    kr_d     = kr_q + 1'b1;
                    kc_d     = '0;
                    issue_rd = 1'b1;
                end else begin
                    kr_d    = '0;
                    kc_d    = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Last element lands now; result is registered for the WRITE cycle.
                wr_en_d    = 1'b1;
                out_addr_d = out_addr_f(32'(ch_q), 32'(orow_q), 32'(ocol_q));
                out_data_d = drop ? '0 : pooled;
                acc_d      = '0;
                state_d    = StWrite;
`ifdef POOL_DROPOUT_STATS_EN
                if (drop && (drop_cnt_q != 16'hFFFF)) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
`endif
            end
            StWrite: begin
                if (train_q) begin
                    lfsr_d = lfsr_next(lfsr_q);
                end
                state_d  = StRead;
                issue_rd = 1'b1;
                if (32'(ocol_q) + 1 < OUT_COLS) begin
                    ocol_d = ocol_q + 1'b1;
                end else begin
                    ocol_d = '0;
                    if (32'(orow_q) + 1 < OUT_ROWS) begin
                        orow_d = orow_q + 1'b1;
                    end else begin
                        orow_d = '0;
                        if (32'(ch_q) + 1 < CHANNELS) begin
                            ch_d = ch_q + 1'b1;
                        end else begin
                            issue_rd = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            state_d  = StFinish;
                        end
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (issue_rd) begin
            rd_en_d   = 1'b1;
            in_addr_d = in_addr_f(32'(ch_d), 32'(orow_d), 32'(ocol_d), 32'(kr_d), 32'(kc_d));
        end

        // Abort wins over everything; bus outputs keep their last values.
        if (bus.abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            rd_en_d    = 1'b0;
            wr_en_d    = 1'b0;
            in_addr_d  = in_addr_q;
            out_addr_d = out_addr_q;
            out_data_d = out_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            ch_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            acc_q       <= '0;
            data_vld_q  <= 1'b0;
            pool_mode_q <= 1'b0;
            train_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
`ifdef POOL_DROPOUT_STATS_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            in_addr_q   <= in_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            ch_q        <= ch_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            acc_q       <= acc_d;
            data_vld_q  <= data_vld_d;
            pool_mode_q <= pool_mode_d;
            train_q     <= train_d;
            lfsr_q      <= lfsr_d;
`ifdef POOL_DROPOUT_STATS_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_rd_en  = rd_en_q;
    assign bus.in_addr   = in_addr_q;
    assign bus.out_wr_en = wr_en_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
`ifdef POOL_DROPOUT_STATS_EN
    assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_pool_dropout_engine.sv
// Bench for pool_dropout_engine. Two instances:
//   A: 2 channels, 4x4, 2x2/s2, PADDING=0, DROP_THRESH=255, input SRAM holds in[i]=i
//   B: 1 channel,  5x5, 2x2/s2, PADDING=1, DROP_THRESH=0,   input SRAM holds in[i]=i
// Expected writes are queued when a run is launched; per-instance monitors pop and compare.
module tb_pool_dropout_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_dropout_engine_if #(.DATA_WIDTH(8), .IN_AW(5), .OUT_AW(3)) ifa ();
    pool_dropout_engine_if #(.DATA_WIDTH(8), .IN_AW(5), .OUT_AW(4)) ifb ();

    pool_dropout_engine #(
        .DATA_WIDTH(8), .CHANNELS(2), .IN_ROWS(4), .IN_COLS(4), .SEG_ROWS(2), .SEG_COLS(2),
        .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(0), .DROP_THRESH(255), .LFSR_SEED(16'hACE1)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    pool_dropout_engine #(
        .DATA_WIDTH(8), .CHANNELS(1), .IN_ROWS(5), .IN_COLS(5), .SEG_ROWS(2), .SEG_COLS(2),
        .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(1), .DROP_THRESH(0), .LFSR_SEED(16'hACE1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    // Input SRAMs: content equals address, one-cycle read latency.
    always @(posedge clk) if (ifa.in_rd_en) ifa.in_data <= 8'(ifa.in_addr);
    always @(posedge clk) if (ifb.in_rd_en) ifb.in_data <= 8'(ifb.in_addr);

    int vectors = 0;
    int miscompares = 0;
    int qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    int done_cnt_a = 0, done_cnt_b = 0;
    int cyc_b = 0, last_wr_b = 0, prev_wr_b = 0;
    logic [15:0] lfsr_a;

    int a_max[8] = '{5, 7, 13, 15, 21, 23, 29, 31};
    int a_avg[8] = '{2, 4, 10, 12, 18, 20, 26, 28};
    int b_max[9] = '{6, 8, 9, 16, 18, 19, 21, 23, 24};
    int b_avg[9] = '{3, 5, 3, 13, 15, 8, 10, 11, 6};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.done) done_cnt_a++;
            if (ifa.in_rd_en && ifa.out_wr_en) check("a_strobe_overlap", 1, 0);
            if (ifa.out_wr_en) begin
                if (qa_addr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL a_unexpected_write: addr %0d data %0d, no write expected",
                             ifa.out_addr, ifa.out_data);
                end else begin
                    check("a_wr_addr", int'(ifa.out_addr), qa_addr.pop_front());
                    check("a_wr_data", int'(ifa.out_data), qa_data.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc_b++;
        if (rst_n) begin
            if (ifb.done) done_cnt_b++;
            if (ifb.in_rd_en && ifb.out_wr_en) check("b_strobe_overlap", 1, 0);
            if (ifb.out_wr_en) begin
                prev_wr_b = last_wr_b;
                last_wr_b = cyc_b;
                if (qb_addr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL b_unexpected_write: addr %0d data %0d, no write expected",
                             ifb.out_addr, ifb.out_data);
                end else begin
                    check("b_wr_addr", int'(ifb.out_addr), qb_addr.pop_front());
                    check("b_wr_data", int'(ifb.out_data), qb_data.pop_front());
                end
            end
        end
    end

    // Returns at the first negedge after start is accepted.
    task automatic start_a(input logic mode, input logic train);
        @(negedge clk);
        ifa.pool_mode = mode;
        ifa.training_mode = train;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    task automatic start_b(input logic mode, input logic train);
        @(negedge clk);
        ifb.pool_mode = mode;
        ifb.training_mode = train;
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
    endtask

    // n counts cycles from the first busy cycle up to and including the done cycle.
    task automatic wait_done_a(input string tag, input int exp_cycles);
        int n = 1;
        check({tag, "_busy_rise"}, int'(ifa.busy), 1);
        while (!ifa.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_cycle"}, n, exp_cycles);
        check({tag, "_busy_at_done"}, int'(ifa.busy), 0);
        @(negedge clk);
        check({tag, "_done_single"}, int'(ifa.done), 0);
        check({tag, "_writes_left"}, qa_addr.size(), 0);
    endtask

    task automatic wait_done_b(input string tag, input int exp_cycles);
        int n = 1;
        check({tag, "_busy_rise"}, int'(ifb.busy), 1);
        while (!ifb.done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_cycle"}, n, exp_cycles);
        check({tag, "_busy_at_done"}, int'(ifb.busy), 0);
        @(negedge clk);
        check({tag, "_done_single"}, int'(ifb.done), 0);
        check({tag, "_writes_left"}, qb_addr.size(), 0);
    endtask

    task automatic push_a_train(output int drops);
        drops = 0;
        for (int i = 0; i < 8; i++) begin
            qa_addr.push_back(i);
            if (lfsr_a[7:0] < 8'd255) begin
                qa_data.push_back(0);
                drops++;
            end else begin
                qa_data.push_back(a_max[i]);
            end
            lfsr_a = lfsr_step(lfsr_a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.pool_mode = 1'b0; ifa.training_mode = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.pool_mode = 1'b0; ifb.training_mode = 1'b0;
        lfsr_a = 16'hACE1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_done", int'(ifa.done), 0);
        check("rst_rd_en", int'(ifa.in_rd_en), 0);
        check("rst_wr_en", int'(ifa.out_wr_en), 0);
        check("rst_out_data", int'(ifa.out_data), 0);
`ifdef POOL_DROPOUT_STATS_EN
        check("rst_drop_count", int'(ifa.drop_count), 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A: max, then avg, no training. 8 windows * 6 cycles + FINISH.
        for (int i = 0; i < 8; i++) begin qa_addr.push_back(i); qa_data.push_back(a_max[i]); end
        done_cnt_a = 0;
        start_a(1'b0, 1'b0);
        wait_done_a("a_max", 49);
        check("a_max_done_pulses", done_cnt_a, 1);
`ifdef POOL_DROPOUT_STATS_EN
        check("a_max_drop_count", int'(ifa.drop_count), 0);
`endif
        for (int i = 0; i < 8; i++) begin qa_addr.push_back(i); qa_data.push_back(a_avg[i]); end
        start_a(1'b1, 1'b0);
        wait_done_a("a_avg", 49);

        // A: training with threshold 255 against the reference LFSR.
        push_a_train(drops);
        start_a(1'b0, 1'b1);
        wait_done_a("a_train", 49);
`ifdef POOL_DROPOUT_STATS_EN
        check("a_train_drop_count", int'(ifa.drop_count), drops);
`endif

        // A: start while busy is ignored; abort in window 1 (READ cycles 7..10).
        qa_addr.push_back(0); qa_data.push_back(5);
        done_cnt_a = 0;
        start_a(1'b0, 1'b0);
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        check("abort_busy", int'(ifa.busy), 0);
        check("abort_rd_en", int'(ifa.in_rd_en), 0);
        check("abort_wr_en", int'(ifa.out_wr_en), 0);
        repeat (60) @(negedge clk);
        check("abort_no_done", done_cnt_a, 0);
        check("abort_writes_left", qa_addr.size(), 0);

        // A: reset in the middle of window 0.
        start_a(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(ifa.busy), 0);
        check("midrst_rd_en", int'(ifa.in_rd_en), 0);
        check("midrst_in_addr", int'(ifa.in_addr), 0);
        check("midrst_out_addr", int'(ifa.out_addr), 0);
        check("midrst_out_data", int'(ifa.out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // LFSR must restart from the seed after reset.
        lfsr_a = 16'hACE1;
        push_a_train(drops);
        start_a(1'b0, 1'b1);
        wait_done_a("a_reseed", 49);
`ifdef POOL_DROPOUT_STATS_EN
        check("a_reseed_drop_count", int'(ifa.drop_count), drops);
`endif

        // B: 5x5 padded; window sizes 4,4,2,4,4,2,2,2,1 -> 25 + 2*9 + 1 = 44 cycles.
        for (int i = 0; i < 9; i++) begin qb_addr.push_back(i); qb_data.push_back(b_max[i]); end
        done_cnt_b = 0;
        start_b(1'b0, 1'b0);
        wait_done_b("b_max", 44);
        check("b_max_done_pulses", done_cnt_b, 1);
        check("b_last_window_cycles", last_wr_b - prev_wr_b, 3);
        for (int i = 0; i < 9; i++) begin qb_addr.push_back(i); qb_data.push_back(b_avg[i]); end
        start_b(1'b1, 1'b0);
        wait_done_b("b_avg", 44);

        // B: training with threshold 0 keeps everything.
        for (int i = 0; i < 9; i++) begin qb_addr.push_back(i); qb_data.push_back(b_max[i]); end
        start_b(1'b0, 1'b1);
        wait_done_b("b_train", 44);
`ifdef POOL_DROPOUT_STATS_EN
        check("b_train_drop_count", int'(ifb.drop_count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
